// File: rtl/stg_id_hs_pkg.sv
// Opcode map, per-opcode class flags and the decode-stage occupancy states.
package stg_id_hs_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } st_t;

    // What an opcode uses. legal=0 leaves every other flag 0.
    typedef struct packed {
        logic legal;
        logic sgn;
        logic imm;
        logic br;
        logic immsr;
        logic tgt_we;
        logic has_tgt;
        logic tgt_sr;
        logic src_gp;
        logic src_sr;
    } cls_t;

    localparam logic [31:0] OP_NOP    = 32'h00;
    localparam logic [31:0] OP_ADD    = 32'h01;
    localparam logic [31:0] OP_ADDU   = 32'h02;
    localparam logic [31:0] OP_SUB    = 32'h03;
    localparam logic [31:0] OP_AND    = 32'h04;
    localparam logic [31:0] OP_OR     = 32'h05;
    localparam logic [31:0] OP_XOR    = 32'h06;
    localparam logic [31:0] OP_MOV    = 32'h07;
    localparam logic [31:0] OP_IADD   = 32'h10;
    localparam logic [31:0] OP_IADDIU = 32'h11;
    localparam logic [31:0] OP_ISUB   = 32'h12;
    localparam logic [31:0] OP_CMP    = 32'h20;
    localparam logic [31:0] OP_LD     = 32'h21;
    localparam logic [31:0] OP_ST     = 32'h22;
    localparam logic [31:0] OP_JCC    = 32'h30;
    localparam logic [31:0] OP_SRJCCU = 32'h31;
    localparam logic [31:0] OP_SRMOVU = 32'h40;
    localparam logic [31:0] OP_MOVSRU = 32'h41;

    function automatic cls_t op_class(input logic [31:0] op);
        cls_t c;
        c = '0;
        c.legal = 1'b1;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB: begin
                c.sgn = 1'b1; c.tgt_we = 1'b1; c.has_tgt = 1'b1; c.src_gp = 1'b1;
            end
            OP_ADDU, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LD: begin
                c.tgt_we = 1'b1; c.has_tgt = 1'b1; c.src_gp = 1'b1;
            end
            OP_IADD, OP_ISUB: begin
                c.sgn = 1'b1; c.imm = 1'b1; c.tgt_we = 1'b1; c.has_tgt = 1'b1;
            end
            OP_IADDIU: begin
                c.imm = 1'b1; c.tgt_we = 1'b1; c.has_tgt = 1'b1;
            end
            // CMP and ST name a GP target that is read, never written.
            OP_CMP: begin
                c.sgn = 1'b1; c.has_tgt = 1'b1; c.src_gp = 1'b1;
            end
            OP_ST: begin
                c.has_tgt = 1'b1; c.src_gp = 1'b1;
            end
            OP_JCC: begin
                c.br = 1'b1; c.imm = 1'b1; c.sgn = 1'b1;
            end
            OP_SRJCCU: begin
                c.br = 1'b1; c.immsr = 1'b1; c.src_sr = 1'b1;
            end
            OP_SRMOVU: begin
                c.tgt_sr = 1'b1; c.src_gp = 1'b1;
            end
            OP_MOVSRU: begin
                c.tgt_we = 1'b1; c.has_tgt = 1'b1; c.src_sr = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stg_id_hs_decode.sv
// Purpose: pure combinational instruction decode (id_decode_comb), fields zeroed unless the class uses them.
// Latency: 0 cycles.
// Backpressure: none; consumed by the stage register write path.
module stg_id_hs_decode
    import stg_id_hs_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int OPC_W   = 8,
    parameter int GP_W    = 4,
    parameter int SR_W    = 2,
    parameter int CC_W    = 4,
    parameter int IMM_W   = 12,
    parameter int IMMSR_W = 10
) (
    input  logic [DATA_W-1:0]  instr,
    output logic [OPC_W-1:0]   opc,
    output logic               sgn_en,
    output logic               imm_en,
    output logic [IMM_W-1:0]   imm_val,
    output logic [IMMSR_W-1:0] immsr_val,
    output logic [CC_W-1:0]    cc,
    output logic [GP_W-1:0]    tgt_gp,
    output logic               tgt_gp_we,
    output logic [SR_W-1:0]    tgt_sr,
    output logic               tgt_sr_we,
    output logic [GP_W-1:0]    src_gp,
    output logic [SR_W-1:0]    src_sr,
    output logic               illegal
);
    localparam int T = DATA_W - OPC_W - 1;

    if ((OPC_W + GP_W + IMM_W > DATA_W) || (OPC_W + CC_W + SR_W + IMMSR_W > DATA_W)
        || (OPC_W > 32)) begin : g_bad_fields
        $error("stg_id_hs: instruction fields do not fit in DATA_W");
    end

    cls_t cls;

    assign opc = instr[DATA_W-1 -: OPC_W];
    assign cls = op_class(32'(opc));

    assign illegal   = ~cls.legal;
    assign sgn_en    = cls.sgn;
    assign imm_en    = cls.imm;
    assign imm_val   = cls.imm     ? instr[IMM_W-1:0]      : '0;
    assign immsr_val = cls.immsr   ? instr[IMMSR_W-1:0]    : '0;
    assign cc        = cls.br      ? instr[T -: CC_W]      : '0;
    assign tgt_gp    = cls.has_tgt ? instr[T -: GP_W]      : '0;
    assign tgt_gp_we = cls.tgt_we;
    assign tgt_sr    = cls.tgt_sr  ? instr[T -: SR_W]      : '0;
    assign tgt_sr_we = cls.tgt_sr;
    assign src_gp    = cls.src_gp  ? instr[T-GP_W -: GP_W] : '0;
    assign src_sr    = cls.src_sr  ? instr[T-CC_W -: SR_W] : '0;

endmodule

// File: rtl/stg_id_hs.sv
// Purpose: instruction-decode stage between IF and EX with valid/ready handshake and optional skid entry.
// Latency: 1 cycle, 1 instruction/cycle throughput.
// Backpressure: SKID_EN=1 ready is registered (low only when both entries full); SKID_EN=0 ready = !ow_valid | iw_ready.
module stg_id_hs
    import stg_id_hs_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 24,
    parameter int OPC_W   = 8,
    parameter int GP_W    = 4,
    parameter int SR_W    = 2,
    parameter int CC_W    = 4,
    parameter int IMM_W   = 12,
    parameter int IMMSR_W = 10,
    parameter int SKID_EN = 1
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    input  logic               iw_valid,
    output logic               ow_ready,
    input  logic [ADDR_W-1:0]  iw_pc,
    input  logic [DATA_W-1:0]  iw_instr,
    input  logic               iw_flush,
    output logic               ow_valid,
    input  logic               iw_ready,
    output logic [ADDR_W-1:0]  ow_pc,
    output logic [DATA_W-1:0]  ow_instr,
    output logic [OPC_W-1:0]   ow_opc,
    output logic               ow_sgn_en,
    output logic               ow_imm_en,
    output logic [IMM_W-1:0]   ow_imm_val,
    output logic [IMMSR_W-1:0] ow_immsr_val,
    output logic [CC_W-1:0]    ow_cc,
    output logic [GP_W-1:0]    ow_tgt_gp,
    output logic               ow_tgt_gp_we,
    output logic [SR_W-1:0]    ow_tgt_sr,
    output logic               ow_tgt_sr_we,
    output logic [GP_W-1:0]    ow_src_gp,
    output logic [SR_W-1:0]    ow_src_sr,
    output logic               ow_illegal
);
    localparam int BW = ADDR_W + DATA_W + OPC_W + 2 + IMM_W + IMMSR_W + CC_W
                      + GP_W + 1 + SR_W + 1 + GP_W + SR_W + 1;

    logic [OPC_W-1:0]   d_opc;
    logic               d_sgn_en, d_imm_en, d_tgt_gp_we, d_tgt_sr_we, d_illegal;
    logic [IMM_W-1:0]   d_imm_val;
    logic [IMMSR_W-1:0] d_immsr_val;
    logic [CC_W-1:0]    d_cc;
    logic [GP_W-1:0]    d_tgt_gp, d_src_gp;
    logic [SR_W-1:0]    d_tgt_sr, d_src_sr;

    logic [BW-1:0] dec_bdl, main_q, main_d, skid_q, skid_d;
    st_t           state_q, state_d;
    logic          accept, pop;

    stg_id_hs_decode #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W),
        .GP_W   (GP_W),
        .SR_W   (SR_W),
        .CC_W   (CC_W),
        .IMM_W  (IMM_W),
        .IMMSR_W(IMMSR_W)
    ) u_dec (
        .instr    (iw_instr),
        .opc      (d_opc),
        .sgn_en   (d_sgn_en),
        .imm_en   (d_imm_en),
        .imm_val  (d_imm_val),
        .immsr_val(d_immsr_val),
        .cc       (d_cc),
        .tgt_gp   (d_tgt_gp),
        .tgt_gp_we(d_tgt_gp_we),
        .tgt_sr   (d_tgt_sr),
        .tgt_sr_we(d_tgt_sr_we),
        .src_gp   (d_src_gp),
        .src_sr   (d_src_sr),
        .illegal  (d_illegal)
    );

    assign dec_bdl = {iw_pc, iw_instr, d_opc, d_sgn_en, d_imm_en, d_imm_val, d_immsr_val,
                      d_cc, d_tgt_gp, d_tgt_gp_we, d_tgt_sr, d_tgt_sr_we, d_src_gp,
                      d_src_sr, d_illegal};

    assign {ow_pc, ow_instr, ow_opc, ow_sgn_en, ow_imm_en, ow_imm_val, ow_immsr_val,
            ow_cc, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we, ow_src_gp,
            ow_src_sr, ow_illegal} = main_q;

    assign ow_valid = (state_q != ST_EMPTY);
    assign ow_ready = (SKID_EN != 0) ? (state_q != ST_TWO) : (~ow_valid | iw_ready);
    assign accept   = iw_valid & ow_ready;
    assign pop      = ow_valid & iw_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = dec_bdl;
                end
            end
            ST_ONE: begin
                if (pop && accept) begin
                    main_d = dec_bdl;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end else if (accept && (SKID_EN != 0)) begin
                    state_d = ST_TWO;
                    skid_d  = dec_bdl;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        // Flush also drops whatever IF presents this cycle.
        if (iw_flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_stg_id_hs.sv
module tb_stg_id_hs;

    typedef struct packed {
        logic [23:0] pc;
        logic [23:0] instr;
        logic [7:0]  opc;
        logic        sgn;
        logic        imm_en;
        logic [11:0] imm;
        logic [9:0]  immsr;
        logic [3:0]  cc;
        logic [3:0]  tgt_gp;
        logic        tgt_gp_we;
        logic [1:0]  tgt_sr;
        logic        tgt_sr_we;
        logic [3:0]  src_gp;
        logic [1:0]  src_sr;
        logic        ill;
    } bdl_t;

    logic iw_clk = 1'b0;
    logic iw_rst = 1'b1;
    always #5 iw_clk = ~iw_clk;

    logic        vld [2];
    logic        rdy_in [2];
    logic        flush [2];
    logic [23:0] pc_in [2];
    logic [23:0] ins_in [2];

    logic        o_rdy [2];
    logic        o_vld [2];
    logic [23:0] o_pc [2];
    logic [23:0] o_ins [2];
    logic [7:0]  o_opc [2];
    logic        o_sgn [2];
    logic        o_imm_en [2];
    logic [11:0] o_imm [2];
    logic [9:0]  o_immsr [2];
    logic [3:0]  o_cc [2];
    logic [3:0]  o_tgt_gp [2];
    logic        o_tgt_gp_we [2];
    logic [1:0]  o_tgt_sr [2];
    logic        o_tgt_sr_we [2];
    logic [3:0]  o_src_gp [2];
    logic [1:0]  o_src_sr [2];
    logic        o_ill [2];

    int errors = 0;
    int checks = 0;

    logic [7:0] legal_ops [18] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                   8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31,
                                   8'h40, 8'h41};

    // dut index g has SKID_EN = g
    for (genvar g = 0; g < 2; g++) begin : g_dut
        stg_id_hs #(.SKID_EN(g)) u_dut (
            .iw_clk      (iw_clk),
            .iw_rst      (iw_rst),
            .iw_valid    (vld[g]),
            .ow_ready    (o_rdy[g]),
            .iw_pc       (pc_in[g]),
            .iw_instr    (ins_in[g]),
            .iw_flush    (flush[g]),
            .ow_valid    (o_vld[g]),
            .iw_ready    (rdy_in[g]),
            .ow_pc       (o_pc[g]),
            .ow_instr    (o_ins[g]),
            .ow_opc      (o_opc[g]),
            .ow_sgn_en   (o_sgn[g]),
            .ow_imm_en   (o_imm_en[g]),
            .ow_imm_val  (o_imm[g]),
            .ow_immsr_val(o_immsr[g]),
            .ow_cc       (o_cc[g]),
            .ow_tgt_gp   (o_tgt_gp[g]),
            .ow_tgt_gp_we(o_tgt_gp_we[g]),
            .ow_tgt_sr   (o_tgt_sr[g]),
            .ow_tgt_sr_we(o_tgt_sr_we[g]),
            .ow_src_gp   (o_src_gp[g]),
            .ow_src_sr   (o_src_sr[g]),
            .ow_illegal  (o_ill[g])
        );
    end

    // Reference decode written per mnemonic: a=[15:12], b=[11:8], sr=[11:10].
    function automatic bdl_t ref_dec(input logic [23:0] pc, input logic [23:0] ins);
        bdl_t e;
        e = '0;
        e.pc = pc;
        e.instr = ins;
        e.opc = ins[23:16];
        case (ins[23:16])
            8'h00: ;
            8'h01, 8'h03: begin
                e.sgn = 1; e.tgt_gp = ins[15:12]; e.tgt_gp_we = 1; e.src_gp = ins[11:8];
            end
            8'h02, 8'h04, 8'h05, 8'h06, 8'h07, 8'h21: begin
                e.tgt_gp = ins[15:12]; e.tgt_gp_we = 1; e.src_gp = ins[11:8];
            end
            8'h10, 8'h12: begin
                e.sgn = 1; e.imm_en = 1; e.imm = ins[11:0];
                e.tgt_gp = ins[15:12]; e.tgt_gp_we = 1;
            end
            8'h11: begin
                e.imm_en = 1; e.imm = ins[11:0]; e.tgt_gp = ins[15:12]; e.tgt_gp_we = 1;
            end
            8'h20: begin
                e.sgn = 1; e.tgt_gp = ins[15:12]; e.src_gp = ins[11:8];
            end
            8'h22: begin
                e.tgt_gp = ins[15:12]; e.src_gp = ins[11:8];
            end
            8'h30: begin
                e.cc = ins[15:12]; e.sgn = 1; e.imm_en = 1; e.imm = ins[11:0];
            end
            8'h31: begin
                e.cc = ins[15:12]; e.src_sr = ins[11:10]; e.immsr = ins[9:0];
            end
            8'h40: begin
                e.tgt_sr = ins[15:14]; e.tgt_sr_we = 1; e.src_gp = ins[11:8];
            end
            8'h41: begin
                e.tgt_gp = ins[15:12]; e.tgt_gp_we = 1; e.src_sr = ins[11:10];
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic bdl_t get_obs(input int d);
        bdl_t b;
        b.pc = o_pc[d];           b.instr = o_ins[d];        b.opc = o_opc[d];
        b.sgn = o_sgn[d];         b.imm_en = o_imm_en[d];    b.imm = o_imm[d];
        b.immsr = o_immsr[d];     b.cc = o_cc[d];            b.tgt_gp = o_tgt_gp[d];
        b.tgt_gp_we = o_tgt_gp_we[d]; b.tgt_sr = o_tgt_sr[d]; b.tgt_sr_we = o_tgt_sr_we[d];
        b.src_gp = o_src_gp[d];   b.src_sr = o_src_sr[d];    b.ill = o_ill[d];
        return b;
    endfunction

    function automatic logic [23:0] rand_instr();
        logic [7:0] op;
        int k;
        k = $urandom_range(0, 21);
        if (k < 18) op = legal_ops[k];
        else op = 8'($urandom);
        return {op, 16'($urandom)};
    endfunction

    task automatic step();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic test_reset();
        bdl_t obs;
        #2;
        for (int d = 0; d < 2; d++) begin
            obs = get_obs(d);
            checks++; if (o_vld[d] !== 1'b0) begin errors++; $display("FAIL reset_valid%0d: got %b want 0", d, o_vld[d]); end
            checks++; if (o_rdy[d] !== 1'b1) begin errors++; $display("FAIL reset_ready%0d: got %b want 1", d, o_rdy[d]); end
            checks++; if (obs !== '0) begin errors++; $display("FAIL reset_bundle%0d: got %h want 0", d, obs); end
        end
        @(negedge iw_clk);
        iw_rst = 1'b0;
        step();
        checks++; if (o_vld[1] !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", o_vld[1]); end
    endtask

    task automatic test_iaddiu();
        bdl_t obs, exp;
        @(negedge iw_clk);
        vld[1] = 1; rdy_in[1] = 1; pc_in[1] = 24'h000100; ins_in[1] = {8'h11, 4'h3, 12'h05A};
        exp = ref_dec(pc_in[1], ins_in[1]);
        step();
        vld[1] = 0;
        obs = get_obs(1);
        checks++; if (o_vld[1] !== 1'b1) begin errors++; $display("FAIL iaddiu_valid: got %b want 1", o_vld[1]); end
        checks++; if (o_tgt_gp[1] !== 4'd3 || o_tgt_gp_we[1] !== 1'b1 || o_imm_en[1] !== 1'b1)
            begin errors++; $display("FAIL iaddiu_tgt: got tgt=%h we=%b imm_en=%b want 3 1 1", o_tgt_gp[1], o_tgt_gp_we[1], o_imm_en[1]); end
        checks++; if (o_imm[1] !== 12'h05A || o_src_gp[1] !== 4'h0)
            begin errors++; $display("FAIL iaddiu_imm: got imm=%h src=%h want 05a 0", o_imm[1], o_src_gp[1]); end
        checks++; if (obs !== exp) begin errors++; $display("FAIL iaddiu_bundle: got %h want %h", obs, exp); end
        step();
        checks++; if (o_vld[1] !== 1'b0) begin errors++; $display("FAIL iaddiu_drain: got %b want 0", o_vld[1]); end
    endtask

    // Leaves dut 1 in the two-entry state holding a then b, with iw_ready low.
    task automatic fill_two(input logic [23:0] a, input logic [23:0] b);
        @(negedge iw_clk);
        rdy_in[1] = 0; vld[1] = 1; pc_in[1] = 24'h000200; ins_in[1] = a;
        step();
        pc_in[1] = 24'h000204; ins_in[1] = b;
        step();
    endtask

    task automatic test_stall();
        bdl_t ea, eb;
        logic [23:0] a, b;
        a = {8'h10, 4'h5, 12'hF01};
        b = {8'h21, 4'h7, 4'h2, 8'h00};
        ea = ref_dec(24'h000200, a);
        eb = ref_dec(24'h000204, b);
        fill_two(a, b);
        vld[1] = 0;
        checks++; if (get_obs(1) !== ea) begin errors++; $display("FAIL stall_head: got %h want %h", get_obs(1), ea); end
        checks++; if (o_rdy[1] !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", o_rdy[1]); end
        step();
        checks++; if (get_obs(1) !== ea || o_vld[1] !== 1'b1) begin errors++; $display("FAIL stall_hold: got %h want %h", get_obs(1), ea); end
        @(negedge iw_clk);
        rdy_in[1] = 1;
        step();
        checks++; if (get_obs(1) !== eb || o_vld[1] !== 1'b1) begin errors++; $display("FAIL stall_skid_out: got %h want %h", get_obs(1), eb); end
        checks++; if (o_rdy[1] !== 1'b1) begin errors++; $display("FAIL stall_ready_back: got %b want 1", o_rdy[1]); end
        step();
        checks++; if (o_vld[1] !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %b want 0", o_vld[1]); end
    endtask

    task automatic test_flush();
        fill_two({8'h01, 16'h1234}, {8'h02, 16'h5678});
        ins_in[1] = {8'h11, 16'h9ABC}; vld[1] = 1; flush[1] = 1;
        step();
        flush[1] = 0; vld[1] = 0; rdy_in[1] = 1;
        checks++; if (o_vld[1] !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", o_vld[1]); end
        checks++; if (get_obs(1) !== '0) begin errors++; $display("FAIL flush_bundle: got %h want 0", get_obs(1)); end
        checks++; if (o_rdy[1] !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", o_rdy[1]); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (o_vld[1] !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b want 0", o_vld[1]); end
        end
    endtask

    task automatic test_illegal();
        @(negedge iw_clk);
        vld[1] = 1; rdy_in[1] = 1; pc_in[1] = 24'h123456; ins_in[1] = {8'hFF, 16'hABCD};
        step();
        vld[1] = 0;
        checks++; if (o_ill[1] !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", o_ill[1]); end
        checks++; if (o_tgt_gp_we[1] !== 1'b0 || o_tgt_sr_we[1] !== 1'b0 || o_imm[1] !== 12'h0)
            begin errors++; $display("FAIL illegal_fields: got we=%b srwe=%b imm=%h want 0 0 0", o_tgt_gp_we[1], o_tgt_sr_we[1], o_imm[1]); end
        checks++; if (o_pc[1] !== 24'h123456 || o_opc[1] !== 8'hFF)
            begin errors++; $display("FAIL illegal_pass: got pc=%h opc=%h want 123456 ff", o_pc[1], o_opc[1]); end
        step();
    endtask

    task automatic test_srjcc();
        @(negedge iw_clk);
        vld[1] = 1; rdy_in[1] = 1; pc_in[1] = 24'h000400; ins_in[1] = {8'h31, 4'h3, 2'b10, 10'h155};
        step();
        vld[1] = 0;
        checks++; if (o_cc[1] !== 4'h3 || o_src_sr[1] !== 2'd2)
            begin errors++; $display("FAIL srjcc_cc_sr: got cc=%h sr=%h want 3 2", o_cc[1], o_src_sr[1]); end
        checks++; if (o_immsr[1] !== 10'h155 || o_imm_en[1] !== 1'b0 || o_tgt_gp[1] !== 4'h0)
            begin errors++; $display("FAIL srjcc_imm: got immsr=%h imm_en=%b tgt=%h want 155 0 0", o_immsr[1], o_imm_en[1], o_tgt_gp[1]); end
        step();
    endtask

    task automatic test_back_to_back();
        bdl_t exp;
        for (int i = 0; i < 6; i++) begin
            @(negedge iw_clk);
            vld[0] = 1; rdy_in[0] = 1; pc_in[0] = 24'(i * 4); ins_in[0] = rand_instr();
            exp = ref_dec(pc_in[0], ins_in[0]);
            step();
            checks++; if (get_obs(0) !== exp || o_vld[0] !== 1'b1 || o_rdy[0] !== 1'b1)
                begin errors++; $display("FAIL b2b_%0d: got %h want %h", i, get_obs(0), exp); end
        end
        vld[0] = 0;
        step();
        checks++; if (o_vld[0] !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", o_vld[0]); end
    endtask

    task automatic test_async_reset();
        fill_two({8'h07, 16'h3300}, {8'h04, 16'h4400});
        #2;
        iw_rst = 1'b1;
        #1;
        checks++; if (o_vld[1] !== 1'b0 || get_obs(1) !== '0)
            begin errors++; $display("FAIL areset_drop: got valid=%b bundle=%h want 0", o_vld[1], get_obs(1)); end
        checks++; if (o_rdy[1] !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b want 1", o_rdy[1]); end
        @(negedge iw_clk);
        iw_rst = 1'b0; vld[1] = 0; rdy_in[1] = 1;
        step();
        checks++; if (o_vld[1] !== 1'b0) begin errors++; $display("FAIL areset_after: got %b want 0", o_vld[1]); end
    endtask

    task automatic test_random(input int d);
        bdl_t q[$];
        bdl_t obs;
        logic exp_rdy;
        for (int c = 0; c < 10000; c++) begin
            @(negedge iw_clk);
            vld[d]    = (c < 9990) && ($urandom_range(0, 3) != 0);
            rdy_in[d] = (c >= 9990) || ($urandom_range(0, 2) != 0);
            pc_in[d]  = 24'($urandom);
            ins_in[d] = rand_instr();
            #1;
            obs = get_obs(d);
            exp_rdy = (d == 1) ? (q.size() < 2) : (q.size() == 0 || rdy_in[d]);
            checks++; if (o_vld[d] !== (q.size() != 0))
                begin errors++; $display("FAIL rnd%0d_valid c=%0d: got %b want %b", d, c, o_vld[d], q.size() != 0); end
            checks++; if (o_rdy[d] !== exp_rdy)
                begin errors++; $display("FAIL rnd%0d_ready c=%0d: got %b want %b", d, c, o_rdy[d], exp_rdy); end
            if (q.size() != 0) begin
                checks++; if (obs !== q[0]) begin errors++; $display("FAIL rnd%0d_data c=%0d: got %h want %h", d, c, obs, q[0]); end
            end else begin
                checks++; if (obs !== '0) begin errors++; $display("FAIL rnd%0d_idle c=%0d: got %h want 0", d, c, obs); end
            end
            if (o_vld[d] && rdy_in[d] && q.size() != 0) void'(q.pop_front());
            if (vld[d] && o_rdy[d]) q.push_back(ref_dec(pc_in[d], ins_in[d]));
        end
        @(negedge iw_clk);
        vld[d] = 0; rdy_in[d] = 1;
        checks++; if (q.size() != 0 || o_vld[d] !== 1'b0)
            begin errors++; $display("FAIL rnd%0d_end: got left=%0d valid=%b want 0 0", d, q.size(), o_vld[d]); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            vld[d] = 0; rdy_in[d] = 1; flush[d] = 0; pc_in[d] = '0; ins_in[d] = '0;
        end
        test_reset();
        test_iaddiu();
        test_stall();
        test_flush();
        test_illegal();
        test_srjcc();
        test_back_to_back();
        test_async_reset();
        test_random(1);
        test_random(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
